global_ram_unloader: RTL and testbench

- Read-side counterpart of the global BRAM load port. Once compute finishes, it reads a byte-addressed region of the global buffer as 128-bit words and streams it out over a valid/ready interface, for OFM dump, golden compare or host readback.
- It sits between the global BRAM read port and the host/debug path. It uses the same word format as the loader: byte 0 is in bits [7:0].

---
 rtl/global_ram_unloader_pkg.sv | 30 +++
 rtl/global_ram_unloader_fifo.sv | 60 ++++++
 rtl/global_ram_unloader.sv | 149 ++++++++++++++
 tb/tb_global_ram_unloader.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/global_ram_unloader_pkg.sv
// Shared types and constants for the global RAM unloader: FSM states, FIFO entry
// layout and the last-beat byte mask helper.
package global_ram_unloader_pkg;

    localparam int BYTES_PER_WORD = 16;
    localparam int WORD_SHIFT     = 4;
    localparam int ENTRY_DATA_W   = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } unload_state_t;

    typedef struct packed {
        logic [ENTRY_DATA_W-1:0]   data;
        logic [BYTES_PER_WORD-1:0] keep;
        logic                      last;
    } fifo_entry_t;

    // A size that is a whole number of words leaves every byte of the last word valid.
    function automatic logic [BYTES_PER_WORD-1:0] last_keep(input logic [WORD_SHIFT-1:0] size_lo);
        if (size_lo == '0) begin
            return '1;
        end
        return (16'd1 << size_lo) - 16'd1;
    endfunction

endpackage

// File: rtl/global_ram_unloader_fifo.sv
// Small synchronous FIFO holding output beats (data, keep, last); the head is
// presented combinationally so it stays stable until popped.
module ram_unload_fifo
    import global_ram_unloader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fifo_entry_t                push_entry,
    input  logic                       pop,
    output fifo_entry_t                head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fifo_entry_t    mem [DEPTH];
    logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic           do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/global_ram_unloader.sv
// Streams a byte-addressed region of the global BRAM out as 128-bit beats over
// valid/ready, never issuing more reads than the output FIFO can absorb.
module global_ram_unloader
    import global_ram_unloader_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] size,
    output logic              rd_en_global,
    output logic [ADDR_W-1:0] rd_addr_global,
    input  logic [DATA_W-1:0] data_rd_global,
    output logic [DATA_W-1:0] m_data,
    output logic [15:0]       m_keep,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              err_unaligned
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    unload_state_t   state_reg, state_next;
    logic [ADDR_W-1:0] word_addr_reg;
    logic [ADDR_W:0]   nwords_reg, issued_reg, nwords_calc;
    logic [WORD_SHIFT-1:0] size_lo_reg;
    logic              err_reg;
    logic [CW-1:0]     outstanding_reg;
    logic [RD_LAT-1:0] vld_sr_reg, last_sr_reg;

    logic        aligned, issue, issue_last, ret, ret_last, pop;
    logic        fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    fifo_entry_t push_entry, fifo_head;

    // One extra bit keeps the round-up from wrapping for sizes near 2^ADDR_W.
    assign nwords_calc = ({1'b0, size} + (ADDR_W+1)'(BYTES_PER_WORD - 1)) >> WORD_SHIFT;
    assign aligned     = (base_addr[WORD_SHIFT-1:0] == '0);
    assign issue       = (state_reg == ST_RUN) &&
                         (({1'b0, fifo_count} + {1'b0, outstanding_reg}) < (CW+1)'(FIFO_DEPTH));
    assign issue_last  = (issued_reg == nwords_reg - 1'b1);
    assign ret         = vld_sr_reg[RD_LAT-1];
    assign ret_last    = last_sr_reg[RD_LAT-1];
    assign pop         = m_valid && m_ready;

    always_comb begin
        push_entry      = '0;
        push_entry.data = data_rd_global;
        push_entry.keep = ret_last ? last_keep(size_lo_reg) : '1;
        push_entry.last = ret_last;
    end

    ram_unload_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (ret),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (!aligned || nwords_calc == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && issue_last) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave on the handshake of the final beat so done follows it by one cycle.
                if (outstanding_reg == '0 && (fifo_empty || (fifo_count == CW'(1) && pop))) begin
                    state_next = ST_FIN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            word_addr_reg   <= '0;
            nwords_reg      <= '0;
            issued_reg      <= '0;
            size_lo_reg     <= '0;
            err_reg         <= 1'b0;
            outstanding_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && start) begin
                word_addr_reg <= base_addr >> WORD_SHIFT;
                nwords_reg    <= nwords_calc;
                issued_reg    <= '0;
                size_lo_reg   <= size[WORD_SHIFT-1:0];
                err_reg       <= !aligned;
            end else if (issue) begin
                word_addr_reg <= word_addr_reg + 1'b1;
                issued_reg    <= issued_reg + 1'b1;
            end
            case ({issue, ret})
                2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
                2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end

    // Read-return tracking: one stage per cycle of BRAM latency.
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_ret_sr
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_sr_reg[gi]  <= 1'b0;
                last_sr_reg[gi] <= 1'b0;
            end else if (gi == 0) begin
                vld_sr_reg[gi]  <= issue;
                last_sr_reg[gi] <= issue && issue_last;
            end else begin
                vld_sr_reg[gi]  <= vld_sr_reg[(gi > 0) ? gi - 1 : 0];
                last_sr_reg[gi] <= last_sr_reg[(gi > 0) ? gi - 1 : 0];
            end
        end
    end

    assign rd_en_global   = issue;
    assign rd_addr_global = word_addr_reg;
    assign m_valid        = !fifo_empty;
    assign m_data         = fifo_empty ? '0 : fifo_head.data;
    assign m_keep         = fifo_empty ? '0 : fifo_head.keep;
    assign m_last         = !fifo_empty && fifo_head.last;
    assign busy           = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign done           = (state_reg == ST_FIN);
    assign err_unaligned  = err_reg;

endmodule

// File: tb/tb_global_ram_unloader.sv
// Directed bench for global_ram_unloader with a one-cycle-latency BRAM model.
module tb_global_ram_unloader;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [31:0]  base_addr, size;
    logic         rd_en_global;
    logic [31:0]  rd_addr_global;
    logic [127:0] data_rd_global;
    logic [127:0] m_data;
    logic [15:0]  m_keep;
    logic         m_last, m_valid, m_ready, busy, done, err_unaligned;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [31:0]  rd_addr_q[$];
    int           rd_cyc_q[$];
    logic [127:0] beat_data_q[$];
    logic [15:0]  beat_keep_q[$];
    bit           beat_last_q[$];
    int           beat_cyc_q[$];
    int           done_cyc_q[$];
    int           first_valid_cyc;
    int           issued, popped, max_inflight;
    bit           rand_ready;

    global_ram_unloader #(.DATA_W(128), .ADDR_W(32), .RD_LAT(1), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .size           (size),
        .rd_en_global   (rd_en_global),
        .rd_addr_global (rd_addr_global),
        .data_rd_global (data_rd_global),
        .m_data         (m_data),
        .m_keep         (m_keep),
        .m_last         (m_last),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .busy           (busy),
        .done           (done),
        .err_unaligned  (err_unaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] word_val(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a + 32'h0101_0101, ~a, a};
    endfunction

    always @(posedge clk) begin
        if (rd_en_global) data_rd_global <= word_val(rd_addr_global);
    end

    // Samples the cycle at the falling edge, then advances past the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (reset) begin
            issued = 0;
            popped = 0;
        end
        if (rd_en_global) begin
            if (issued - popped + 1 > max_inflight) max_inflight = issued - popped + 1;
            rd_addr_q.push_back(rd_addr_global);
            rd_cyc_q.push_back(cyc);
            issued++;
        end
        if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_valid && m_ready) begin
            beat_data_q.push_back(m_data);
            beat_keep_q.push_back(m_keep);
            beat_last_q.push_back(m_last);
            beat_cyc_q.push_back(cyc);
            popped++;
        end
        if (done) done_cyc_q.push_back(cyc);
        @(posedge clk);
        cyc++;
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_mon();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        beat_data_q.delete();
        beat_keep_q.delete();
        beat_last_q.delete();
        beat_cyc_q.delete();
        done_cyc_q.delete();
        first_valid_cyc = -1;
        max_inflight = 0;
    endtask

    task automatic launch(input logic [31:0] b, input logic [31:0] s, output int c0);
        base_addr = b;
        size = s;
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cyc_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        size = '0;
        m_ready = 1'b1;
        rand_ready = 1'b0;
        clear_mon();
        repeat (3) tick();
        tests++;
        if ({rd_en_global, m_valid, busy, done, err_unaligned, m_last, m_keep, m_data, rd_addr_global} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got en=%b v=%b busy=%b done=%b err=%b keep=%h want all 0",
                     rd_en_global, m_valid, busy, done, err_unaligned, m_keep);
        end
        reset = 1'b0;
        repeat (2) tick();
        tests++;
        if ({rd_en_global, m_valid, busy, done} !== 4'b0) begin
            fails++;
            $display("FAIL reset_idle: got en=%b v=%b busy=%b done=%b want 0", rd_en_global, m_valid, busy, done);
        end
        $display("[TB] reset: done");
    endtask

    task automatic test_zero_unaligned();
        bit ok;
        int c0;
        clear_mon();
        launch(32'h40, 32'h0, c0);
        run_until_done(10, ok);
        repeat (3) tick();
        tests++;
        if (!ok || done_cyc_q.size() != 1 || done_cyc_q[0] != c0 + 1) begin
            fails++;
            $display("FAIL zero_done: got ok=%b pulses=%0d want one pulse at cycle %0d", ok, done_cyc_q.size(), c0 + 1);
        end
        tests++;
        if (rd_addr_q.size() != 0 || first_valid_cyc != -1 || err_unaligned !== 1'b0) begin
            fails++;
            $display("FAIL zero_quiet: got reads=%0d valid_cyc=%0d err=%b want 0,-1,0", rd_addr_q.size(), first_valid_cyc, err_unaligned);
        end
        $display("[TB] zero size: reads=%0d done_pulses=%0d", rd_addr_q.size(), done_cyc_q.size());

        clear_mon();
        launch(32'h8, 32'h40, c0);
        run_until_done(10, ok);
        repeat (3) tick();
        tests++;
        if (!ok || done_cyc_q.size() != 1) begin
            fails++;
            $display("FAIL unaligned_done: got ok=%b pulses=%0d want 1", ok, done_cyc_q.size());
        end
        tests++;
        if (err_unaligned !== 1'b1) begin
            fails++;
            $display("FAIL unaligned_err: got %b want 1", err_unaligned);
        end
        tests++;
        if (rd_addr_q.size() != 0 || first_valid_cyc != -1) begin
            fails++;
            $display("FAIL unaligned_quiet: got reads=%0d valid_cyc=%0d want 0,-1", rd_addr_q.size(), first_valid_cyc);
        end
        $display("[TB] unaligned: err=%b reads=%0d", err_unaligned, rd_addr_q.size());
    endtask

    task automatic test_aligned();
        bit ok;
        int c0;
        clear_mon();
        m_ready = 1'b1;
        launch(32'h32C40, 32'h40, c0);
        tests++;
        if (err_unaligned !== 1'b0) begin
            fails++;
            $display("FAIL aligned_err_clear: got %b want 0", err_unaligned);
        end
        run_until_done(100, ok);
        repeat (3) tick();
        tests++;
        if (!ok || rd_addr_q.size() != 4) begin
            fails++;
            $display("FAIL aligned_reads: got ok=%b reads=%0d want 1,4", ok, rd_addr_q.size());
        end
        for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
            tests++;
            if (rd_addr_q[i] !== 32'h32C4 + i || rd_cyc_q[i] != c0 + 1 + i) begin
                fails++;
                $display("FAIL aligned_addr[%0d]: got %h@%0d want %h@%0d", i, rd_addr_q[i], rd_cyc_q[i], 32'h32C4 + i, c0 + 1 + i);
            end
        end
        tests++;
        if (first_valid_cyc != c0 + 3) begin
            fails++;
            $display("FAIL aligned_latency: got m_valid at %0d want %0d", first_valid_cyc, c0 + 3);
        end
        tests++;
        if (beat_data_q.size() != 4) begin
            fails++;
            $display("FAIL aligned_beats: got %0d want 4", beat_data_q.size());
        end
        for (int i = 0; i < 4 && i < beat_data_q.size(); i++) begin
            tests++;
            if (beat_data_q[i] !== word_val(32'h32C4 + i) || beat_keep_q[i] !== 16'hFFFF || beat_last_q[i] != (i == 3)) begin
                fails++;
                $display("FAIL aligned_beat[%0d]: got %h keep=%h last=%b want %h keep=ffff last=%b",
                         i, beat_data_q[i], beat_keep_q[i], beat_last_q[i], word_val(32'h32C4 + i), i == 3);
            end
        end
        tests++;
        if (done_cyc_q.size() != 1 || beat_cyc_q.size() != 4 || done_cyc_q[0] != beat_cyc_q[3] + 1) begin
            fails++;
            $display("FAIL aligned_done: got pulses=%0d want one pulse right after the last handshake", done_cyc_q.size());
        end
        $display("[TB] aligned: beats=%0d first_valid=%0d", beat_data_q.size(), first_valid_cyc - c0);
    endtask

    task automatic test_partial();
        bit ok;
        int c0;
        clear_mon();
        m_ready = 1'b1;
        launch(32'h0, 32'h24, c0);
        run_until_done(100, ok);
        repeat (2) tick();
        tests++;
        if (!ok || beat_data_q.size() != 3) begin
            fails++;
            $display("FAIL partial_beats: got ok=%b beats=%0d want 1,3", ok, beat_data_q.size());
        end
        for (int i = 0; i < 3 && i < beat_data_q.size(); i++) begin
            tests++;
            if (beat_data_q[i] !== word_val(i) || beat_keep_q[i] !== ((i == 2) ? 16'h000F : 16'hFFFF) || beat_last_q[i] != (i == 2)) begin
                fails++;
                $display("FAIL partial_beat[%0d]: got %h keep=%h last=%b want %h keep=%h last=%b",
                         i, beat_data_q[i], beat_keep_q[i], beat_last_q[i], word_val(i), (i == 2) ? 16'h000F : 16'hFFFF, i == 2);
            end
        end
        $display("[TB] partial: beats=%0d", beat_data_q.size());
    endtask

    task automatic test_backpressure();
        bit ok;
        int c0, nb;
        logic [127:0] held;
        clear_mon();
        m_ready = 1'b1;
        launch(32'h1000, 32'h100, c0);
        for (int i = 0; i < 50 && beat_data_q.size() < 3; i++) tick();
        m_ready = 1'b0;
        tick();
        held = m_data;
        nb = beat_data_q.size();
        repeat (5) tick();
        tests++;
        if (m_valid !== 1'b1 || m_data !== held || rd_en_global !== 1'b0 || beat_data_q.size() != nb) begin
            fails++;
            $display("FAIL bp_stall: got v=%b held=%b rd_en=%b new_beats=%0d want 1,1,0,0",
                     m_valid, m_data === held, rd_en_global, beat_data_q.size() - nb);
        end
        rand_ready = 1'b1;
        run_until_done(500, ok);
        rand_ready = 1'b0;
        m_ready = 1'b1;
        repeat (2) tick();
        tests++;
        if (!ok || beat_data_q.size() != 16 || rd_addr_q.size() != 16) begin
            fails++;
            $display("FAIL bp_count: got ok=%b beats=%0d reads=%0d want 1,16,16", ok, beat_data_q.size(), rd_addr_q.size());
        end
        for (int i = 0; i < 16 && i < beat_data_q.size(); i++) begin
            tests++;
            if (beat_data_q[i] !== word_val(32'h100 + i) || beat_last_q[i] != (i == 15)) begin
                fails++;
                $display("FAIL bp_beat[%0d]: got %h last=%b want %h last=%b", i, beat_data_q[i], beat_last_q[i], word_val(32'h100 + i), i == 15);
            end
        end
        tests++;
        if (max_inflight > 4) begin
            fails++;
            $display("FAIL bp_overflow: got inflight %0d want <= 4", max_inflight);
        end
        $display("[TB] backpressure: beats=%0d max_inflight=%0d", beat_data_q.size(), max_inflight);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int c0;
        clear_mon();
        m_ready = 1'b1;
        launch(32'h4000, 32'h100, c0);
        for (int i = 0; i < 50 && beat_data_q.size() < 3; i++) tick();
        reset = 1'b1;
        #1;
        tests++;
        if ({rd_en_global, m_valid, busy, done, err_unaligned, m_last, m_keep, m_data, rd_addr_global} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got en=%b v=%b busy=%b done=%b keep=%h want all 0",
                     rd_en_global, m_valid, busy, done, m_keep);
        end
        repeat (2) tick();
        reset = 1'b0;
        clear_mon();
        repeat (4) tick();
        tests++;
        if (beat_data_q.size() != 0 || rd_addr_q.size() != 0 || done_cyc_q.size() != 0) begin
            fails++;
            $display("FAIL midreset_quiet: got beats=%0d reads=%0d done=%0d want 0", beat_data_q.size(), rd_addr_q.size(), done_cyc_q.size());
        end
        launch(32'h2000, 32'h20, c0);
        run_until_done(100, ok);
        repeat (2) tick();
        tests++;
        if (!ok || beat_data_q.size() != 2) begin
            fails++;
            $display("FAIL midreset_restart: got ok=%b beats=%0d want 1,2", ok, beat_data_q.size());
        end
        for (int i = 0; i < 2 && i < beat_data_q.size(); i++) begin
            tests++;
            if (beat_data_q[i] !== word_val(32'h200 + i) || beat_keep_q[i] !== 16'hFFFF || beat_last_q[i] != (i == 1)) begin
                fails++;
                $display("FAIL midreset_beat[%0d]: got %h last=%b want %h last=%b", i, beat_data_q[i], beat_last_q[i], word_val(32'h200 + i), i == 1);
            end
        end
        $display("[TB] reset mid-transfer: restart beats=%0d", beat_data_q.size());
    endtask

    task automatic test_start_busy();
        bit ok;
        int c0;
        clear_mon();
        m_ready = 1'b1;
        launch(32'h3000, 32'h40, c0);
        tick();
        base_addr = 32'h5000;
        size = 32'h100;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_done(100, ok);
        repeat (20) tick();
        tests++;
        if (!ok || done_cyc_q.size() != 1 || beat_data_q.size() != 4 || rd_addr_q.size() != 4) begin
            fails++;
            $display("FAIL busy_ignore: got ok=%b done=%0d beats=%0d reads=%0d want 1,1,4,4",
                     ok, done_cyc_q.size(), beat_data_q.size(), rd_addr_q.size());
        end
        for (int i = 0; i < 4 && i < beat_data_q.size(); i++) begin
            tests++;
            if (beat_data_q[i] !== word_val(32'h300 + i)) begin
                fails++;
                $display("FAIL busy_beat[%0d]: got %h want %h", i, beat_data_q[i], word_val(32'h300 + i));
            end
        end
        $display("[TB] start while busy: beats=%0d done_pulses=%0d", beat_data_q.size(), done_cyc_q.size());
    endtask

    initial begin
        test_reset();
        test_zero_unaligned();
        test_aligned();
        test_partial();
        test_backpressure();
        test_reset_mid();
        test_start_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
